// File: rtl/token_multiplier.sv
// Token multiplier: every input token on a expands into K serial ones on b,
// with a bounded backlog counter and a sticky overflow error.
module token_multiplier #(
    parameter int F_W   = 4,
    parameter int DEPTH = 200,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic [F_W-1:0]   factor,
    output logic             b,
    output logic [CNT_W-1:0] pending,
    output logic             busy,
    output logic             overflow
);

    localparam int SUM_W = CNT_W + F_W + 1;

    typedef enum logic {
        ST_RUN,
        ST_OVF
    } state_t;

    state_t           state_q, state_d;
    logic             b_q, b_d;
    logic [CNT_W-1:0] pending_q, pending_d;
    logic [F_W-1:0]   k_q, k_d;

    logic [F_W-1:0]   k_sel;
    logic [F_W-1:0]   k_eff;
    logic [SUM_W-1:0] sum;
    logic             ovf_hit;

    // An idle counter means this token starts a new burst and takes the live factor.
    always_comb begin
        k_sel   = (pending_q == '0) ? factor : k_q;
        k_eff   = (k_sel == '0) ? F_W'(1) : k_sel;
        sum     = SUM_W'(pending_q) + SUM_W'(k_eff) - SUM_W'(1);
        ovf_hit = a && (sum > SUM_W'(DEPTH));
    end

    always_comb begin
        state_d   = state_q;
        b_d       = 1'b0;
        pending_d = pending_q;
        k_d       = k_q;
        case (state_q)
            ST_RUN: begin
                if (a) begin
                    if (ovf_hit) begin
                        state_d = ST_OVF;
                    end else begin
                        b_d       = 1'b1;
                        pending_d = sum[CNT_W-1:0];
                        if (pending_q == '0) k_d = k_eff;
                    end
                end else if (pending_q != '0) begin
                    b_d       = 1'b1;
                    pending_d = pending_q - CNT_W'(1);
                end
            end
            ST_OVF: begin
                b_d = 1'b0;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_RUN;
            b_q       <= 1'b0;
            pending_q <= '0;
            k_q       <= F_W'(1);
        end else begin
            state_q   <= state_d;
            b_q       <= b_d;
            pending_q <= pending_d;
            k_q       <= k_d;
        end
    end

    assign b        = b_q;
    assign pending  = pending_q;
    assign busy     = |pending_q;
    assign overflow = (state_q == ST_OVF);

endmodule

// File: tb/tb_token_multiplier.sv
// Directed self-checking bench for token_multiplier with default parameters.
module tb_token_multiplier;

    localparam int F_W   = 4;
    localparam int DEPTH = 200;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst;
    logic             a;
    logic [F_W-1:0]   factor;
    logic             b;
    logic [CNT_W-1:0] pending;
    logic             busy;
    logic             overflow;

    int errors = 0;
    int checks = 0;

    token_multiplier #(.F_W(F_W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .factor   (factor),
        .b        (b),
        .pending  (pending),
        .busy     (busy),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        a      = 1'b0;
        factor = '0;
        rst    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1; a = 1'b0; factor = '0;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (b !== 1'b0 || pending !== 8'd0 || overflow !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: b=%b pending=%0d ovf=%b busy=%b, want 0 0 0 0", b, pending, overflow, busy);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        tick;
        checks++;
        if (b !== 1'b0 || pending !== 8'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: b=%b pending=%0d ovf=%b, want 0 0 0", b, pending, overflow);
        end
    endtask

    task automatic test_pattern_k2;
        logic [25:0] av;
        logic [25:0] bv;
        av = 26'b10010011000110100001100100;
        bv = 26'b11011011110111111001111110;
        do_reset;
        factor = 4'd2;
        for (int i = 0; i < 26; i++) begin
            a = av[25-i];
            tick;
            checks++;
            if (b !== bv[25-i] || overflow !== 1'b0) begin
                errors++;
                $display("FAIL k2_pattern[%0d]: b=%b ovf=%b, want b=%b ovf=0", i, b, overflow, bv[25-i]);
            end
        end
        a = 1'b0;
    endtask

    task automatic test_single_k3;
        logic [5:0] exp_b;
        int         exp_p [6];
        exp_b = 6'b111000;
        exp_p = '{2, 1, 0, 0, 0, 0};
        do_reset;
        factor = 4'd3;
        for (int i = 0; i < 6; i++) begin
            a = (i == 0);
            tick;
            checks++;
            if (b !== exp_b[5-i] || pending !== CNT_W'(exp_p[i]) || busy !== (exp_p[i] != 0)) begin
                errors++;
                $display("FAIL k3_single[%0d]: b=%b pending=%0d busy=%b, want %b %0d %b",
                         i, b, pending, busy, exp_b[5-i], exp_p[i], exp_p[i] != 0);
            end
        end
    endtask

    task automatic test_factor_change;
        do_reset;
        factor = 4'd4; a = 1'b1;
        tick;
        checks++;
        if (pending !== 8'd3 || b !== 1'b1) begin
            errors++;
            $display("FAIL fchg_start: pending=%0d b=%b, want 3 1", pending, b);
        end
        factor = 4'd2; a = 1'b0;
        tick;
        tick;
        checks++;
        if (pending !== 8'd1) begin
            errors++;
            $display("FAIL fchg_drain: pending=%0d, want 1", pending);
        end
        a = 1'b1;
        tick;
        checks++;
        if (pending !== 8'd4 || b !== 1'b1) begin
            errors++;
            $display("FAIL fchg_latched_k: pending=%0d b=%b, want 4 1", pending, b);
        end
        // Drain fully, then a new burst must pick up the new factor of 2.
        a = 1'b0;
        repeat (4) tick;
        a = 1'b1;
        tick;
        checks++;
        if (pending !== 8'd1) begin
            errors++;
            $display("FAIL fchg_new_k: pending=%0d, want 1", pending);
        end
        a = 1'b0;
    endtask

    task automatic test_k1_delay;
        logic [15:0] av;
        logic        prev;
        av = 16'b1101001110001011;
        for (int f = 0; f < 2; f++) begin
            do_reset;
            factor = F_W'(f);
            prev   = 1'b0;
            for (int i = 0; i < 16; i++) begin
                a = av[15-i];
                tick;
                checks++;
                if (b !== av[15-i] || pending !== 8'd0 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL k1_delay f=%0d [%0d]: b=%b pending=%0d busy=%b, want b=%b pending=0 busy=0",
                             f, i, b, pending, busy, av[15-i]);
                end
                prev = av[15-i];
            end
            a = 1'b0;
            tick;
            checks++;
            if (b !== 1'b0 || prev !== 1'b1) begin
                errors++;
                $display("FAIL k1_tail f=%0d: b=%b, want 0", f, b);
            end
        end
    endtask

    task automatic test_overflow;
        do_reset;
        factor = 4'd2; a = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick;
            if (i == 0 || i == 199) begin
                checks++;
                if (pending !== CNT_W'(i + 1) || b !== 1'b1 || overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_fill[%0d]: pending=%0d b=%b ovf=%b, want %0d 1 0",
                             i, pending, b, overflow, i + 1);
                end
            end
        end
        checks++;
        if (pending !== 8'd200 || busy !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_equal_depth: pending=%0d busy=%b ovf=%b, want 200 1 0", pending, busy, overflow);
        end
        tick;
        checks++;
        if (overflow !== 1'b1 || b !== 1'b0 || pending !== 8'd200) begin
            errors++;
            $display("FAIL ovf_detect: ovf=%b b=%b pending=%0d, want 1 0 200", overflow, b, pending);
        end
        for (int i = 0; i < 50; i++) begin
            a      = i[0];
            factor = F_W'(i);
            tick;
            checks++;
            if (overflow !== 1'b1 || b !== 1'b0 || pending !== 8'd200) begin
                errors++;
                $display("FAIL ovf_sticky[%0d]: ovf=%b b=%b pending=%0d, want 1 0 200", i, overflow, b, pending);
            end
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (overflow !== 1'b0 || pending !== 8'd0 || b !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ovf_async_clear: ovf=%b pending=%0d b=%b busy=%b, want 0 0 0 0", overflow, pending, b, busy);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        a = 1'b1; factor = 4'd3;
        tick;
        checks++;
        if (pending !== 8'd2 || b !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_resume: pending=%0d b=%b ovf=%b, want 2 1 0", pending, b, overflow);
        end
        a = 1'b0;
    endtask

    initial begin
        a = 1'b0; factor = '0; rst = 1'b1;
        test_reset;
        test_pattern_k2;
        test_single_k3;
        test_factor_change;
        test_k1_delay;
        test_overflow;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, want completion");
        $fatal(1);
    end

endmodule
